muldiv_seq: RTL and testbench

Multi-cycle sequencer for the signed MULT/DIV instructions of the multicycle CPU. It owns the HI/LO result pair that feeds the register-file write-back mux. It is started by the control unit with operands from registers A/B and iterates one bit per clock: radix-2 Booth for MULT, restoring division for DIV. It reports completion and divide-by-zero back to the control unit so the FSM can stall or enter the exception path.

---
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential signed MULT/DIV unit owning the HI/LO pair.
// MULT is radix-2 Booth and DIV is restoring division on magnitudes.
// Both retire one bit per clock.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  // acc carries one guard bit so Booth add/sub of the most negative multiplicand cannot overflow
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   mul_acc;
  logic [WIDTH-1:0] mul_q;
  logic             mul_qm1;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   div_acc;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Operand magnitudes for division setup
  always_comb begin
    a_abs = a[WIDTH-1] ? -a : a;
    b_abs = b[WIDTH-1] ? -b : b;
  end

  // One Booth step: add/sub multiplicand per {q0, q-1}, then arithmetic shift right
  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   acc_sum = acc_q - {m_q[WIDTH-1], m_q};
      default: acc_sum = acc_q;
    endcase
    {mul_acc, mul_q, mul_qm1} = {acc_sum[WIDTH], acc_sum, q_q};
  end

  // One restoring-division step plus sign fix-up of the final quotient/remainder
  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, m_q};
    if (!div_diff[WIDTH+1]) begin
      div_acc = div_diff[WIDTH:0];
      div_q   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = div_shift;
      div_q   = {q_q[WIDTH-2:0], 1'b0};
    end
    div_lo = neg_quo_q ? -div_q : div_q;
    div_hi = neg_rem_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op && (b == '0)) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d   = CW'(WIDTH);
            op_d    = op;
            acc_d   = '0;
            qm1_d   = 1'b0;
            if (op) begin
              q_d       = a_abs;
              m_d       = b_abs;
              neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem_d = a[WIDTH-1];
            end else begin
              q_d = b;
              m_d = a;
            end
          end
        end
      end
      S_RUN: begin
        cnt_d = CW'(cnt_q - 1'b1);
        if (op_q) begin
          acc_d = div_acc;
          q_d   = div_q;
        end else begin
          acc_d = mul_acc;
          q_d   = mul_q;
          qm1_d = mul_qm1;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (op_q) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = mul_acc[WIDTH-1:0];
            lo_d = mul_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table plus hand sequences, scoreboard checked on done.
module tb_muldiv_seq;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          failures;
  vec_t        sb[$];
  vec_t        tbl[$];
  vec_t        e_mon;
  logic [31:0] mhi;
  logic [31:0] mlo;

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model built on 64-bit signed arithmetic
  function automatic vec_t mk(input logic o, input logic [31:0] x, input logic [31:0] y);
    vec_t   v;
    longint sx;
    longint sy;
    longint p;
    longint qt;
    longint rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    v.op = o;
    v.a  = x;
    v.b  = y;
    v.dz = 1'b0;
    if (!o) begin
      p    = sx * sy;
      v.hi = p[63:32];
      v.lo = p[31:0];
    end else begin
      qt   = sx / sy;
      rm   = sx % sy;
      v.hi = rm[31:0];
      v.lo = qt[31:0];
    end
    return v;
  endfunction

  // Scoreboard: compare results whenever done pulses
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done act=1 exp=0");
      end else begin
        e_mon = sb.pop_front();
        chk("hi", 72'(hi), 72'(e_mon.hi));
        chk("lo", 72'(lo), 72'(e_mon.lo));
        chk("div_zero", 72'(div_zero), 72'(e_mon.dz));
      end
    end
  end

  // Issue one operation and check cycle-by-cycle protocol; optional ignored start / mid-run reset
  task automatic do_op(input vec_t v, input int poke_cyc, input int rst_cyc);
    int last;
    @(negedge clk);
    chk("idle", 72'({busy, done, div_zero}), 72'(0));
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    sb.push_back(v);
    last = v.dz ? 1 : WIDTH + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = (c == poke_cyc);
      if (c == poke_cyc) begin
        op = 1'b1;
        b  = '0;
      end else begin
        op = 1'($urandom);
        a  = $urandom;
        b  = $urandom;
      end
      if (c == rst_cyc) begin
        reset = 1'b0;
        #1;
        chk("rst_out", 72'({busy, done, div_zero, hi, lo}), 72'(0));
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold", 72'({busy, done, div_zero, hi, lo}), 72'(0));
        end
        start = 1'b0;
        reset = 1'b1;
        sb.delete();
        mhi = '0;
        mlo = '0;
        return;
      end
      if (c < last)
        chk("run", 72'({busy, done, div_zero, hi, lo}), 72'({1'b1, 1'b0, 1'b0, mhi, mlo}));
      else
        chk("fin", 72'({busy, done}), 72'(2'b01));
    end
    start = 1'b0;
    if (!v.dz) begin
      mhi = v.hi;
      mlo = v.lo;
    end
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    mhi      = '0;
    mlo      = '0;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 72'({busy, done, div_zero, hi, lo}), 72'(0));
    reset = 1'b1;

    tbl.push_back('{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    tbl.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    tbl.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0});
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i < 4) ? $urandom : 32'($urandom_range(1, 1000));
      if (rb == 0) rb = 32'd3;
      tbl.push_back(mk(1'(i % 2), ra, rb));
    end
    for (int i = 0; i < tbl.size(); i++)
      do_op(tbl[i], -1, -1);

    // Preload HI/LO, then divide by zero must leave them untouched
    do_op(mk(1'b1, 32'h0000_0451, 32'h0000_0020), -1, -1);
    v = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1};
    do_op(v, -1, -1);

    // Start pulse during RUN is ignored
    do_op(mk(1'b0, 32'd3, 32'd4), 10, -1);
    // Reset mid-run clears everything, then a normal op
    do_op(mk(1'b0, 32'd3, 32'd4), -1, 15);
    do_op(mk(1'b0, 32'd2, 32'd5), -1, -1);

    repeat (2) @(negedge clk);
    chk("sb_drain", 72'(sb.size()), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
